// File: rtl/forward_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : forward_ctrl_if
//  Purpose  : Bundles the decode-stage operand/producer information and the
//             forwarding/stall results exchanged with forward_ctrl.
//  Ports    : valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_ID,
//             wrReg_ID, isLoad_ID, flush        (decode side -> controller)
//             reg_forward_sel1, reg_forward_sel2, stall,
//             stall_count                       (controller -> pipeline)
//  Modports : master drives decode info, slave is the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface forward_ctrl_if #(
   parameter int REG_BITS = 4,
   parameter int CNT_BITS = 16
);
   logic                valid_ID;
   logic [REG_BITS-1:0] rs1_ID;
   logic [REG_BITS-1:0] rs2_ID;
   logic                rs1_used_ID;
   logic                rs2_used_ID;
   logic [REG_BITS-1:0] rd_ID;
   logic                wrReg_ID;
   logic                isLoad_ID;
   logic                flush;
   logic [1:0]          reg_forward_sel1;
   logic [1:0]          reg_forward_sel2;
   logic                stall;
   logic [CNT_BITS-1:0] stall_count;

   modport master (
      output valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
             rd_ID, wrReg_ID, isLoad_ID, flush,
      input  reg_forward_sel1, reg_forward_sel2, stall, stall_count
   );

   modport slave (
      input  valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
             rd_ID, wrReg_ID, isLoad_ID, flush,
      output reg_forward_sel1, reg_forward_sel2, stall, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : forward_ctrl
//  Purpose  : Operand-forwarding and load-use hazard controller for a
//             five-stage pipeline. Tracks the producers sitting in EX, MEM
//             and WB and picks the youngest one for each decode operand.
//  Ports    : clk      - rising-edge clock
//             reset_n  - asynchronous active-low reset
//             bus      - forward_ctrl_if.slave (decode info in, selects,
//                        stall and saturating stall counter out)
//  Revision : 1.0 - initial release
// ============================================================================
module forward_ctrl #(
   parameter int REG_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   forward_ctrl_if.slave bus
);

   localparam logic [1:0]          c_SEL_NONE = 2'd0;
   localparam logic [1:0]          c_SEL_EX   = 2'd1;
   localparam logic [1:0]          c_SEL_MEM  = 2'd2;
   localparam logic [1:0]          c_SEL_WB   = 2'd3;
   localparam logic [CNT_BITS-1:0] c_CNT_MAX  = '1;

   typedef struct packed {
      logic                v;
      logic                wr;
      logic                ld;
      logic [REG_BITS-1:0] rd;
   } slot_t;

   slot_t               r_slotEx;
   slot_t               r_slotMem;
   slot_t               r_slotWb;
   logic [CNT_BITS-1:0] r_stallCount;

   logic [1:0] w_sel1;
   logic [1:0] w_sel2;
   logic       w_loadUse1;
   logic       w_loadUse2;
   logic       w_stall;
   logic       w_issue;

   // Register 0 is hard-wired, so a "write" to it never produces a value.
   function automatic logic writesReg(input slot_t s, input logic [REG_BITS-1:0] r);
      return s.v && s.wr && (s.rd == r) && (r != '0);
   endfunction

   // Youngest producer first: EX beats MEM beats WB.
   function automatic logic [1:0] pickSource(
      input logic                valid,
      input logic                used,
      input logic [REG_BITS-1:0] r,
      input slot_t               ex,
      input slot_t               mem,
      input slot_t               wb
   );
      logic [1:0] sel;
      sel = c_SEL_NONE;
      if (valid && used) begin
         if (writesReg(ex, r))       sel = c_SEL_EX;
         else if (writesReg(mem, r)) sel = c_SEL_MEM;
         else if (writesReg(wb, r))  sel = c_SEL_WB;
      end
      return sel;
   endfunction

   always_comb begin
      w_sel1 = pickSource(bus.valid_ID, bus.rs1_used_ID, bus.rs1_ID,
                          r_slotEx, r_slotMem, r_slotWb);
      w_sel2 = pickSource(bus.valid_ID, bus.rs2_used_ID, bus.rs2_ID,
                          r_slotEx, r_slotMem, r_slotWb);

      // A load in EX has no data yet, so a dependent decode must wait one
      // cycle; by then the load sits in MEM and forwards normally.
      w_loadUse1 = bus.rs1_used_ID && r_slotEx.ld && writesReg(r_slotEx, bus.rs1_ID);
      w_loadUse2 = bus.rs2_used_ID && r_slotEx.ld && writesReg(r_slotEx, bus.rs2_ID);

      // A flush squashes the decode slot, so there is nothing to hold.
      w_stall = bus.valid_ID && !bus.flush && (w_loadUse1 || w_loadUse2);
      w_issue = bus.valid_ID && !bus.flush && !w_stall;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_slotEx     <= '0;
         r_slotMem    <= '0;
         r_slotWb     <= '0;
         r_stallCount <= '0;
      end else begin
         r_slotWb  <= r_slotMem;
         r_slotMem <= r_slotEx;
         if (w_issue) begin
            r_slotEx <= '{v: 1'b1, wr: bus.wrReg_ID, ld: bus.isLoad_ID, rd: bus.rd_ID};
         end else begin
            r_slotEx <= '0;
         end
         if (w_stall && (r_stallCount != c_CNT_MAX)) begin
            r_stallCount <= r_stallCount + 1'b1;
         end
      end
   end

   // Slots are cleared asynchronously, so selects and stall fall to zero as
   // soon as reset asserts without any extra gating.
   assign bus.reg_forward_sel1 = w_sel1;
   assign bus.reg_forward_sel2 = w_sel2;
   assign bus.stall            = w_stall;
   assign bus.stall_count      = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_forward_ctrl
//  Purpose  : Directed self-checking bench for forward_ctrl. Two instances
//             receive identical decode stimulus: one with the default
//             16-bit stall counter and one with a 2-bit counter for
//             saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_forward_ctrl;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   forward_ctrl_if #(.REG_BITS(4), .CNT_BITS(16)) busA ();
   forward_ctrl_if #(.REG_BITS(4), .CNT_BITS(2))  busB ();

   forward_ctrl #(.REG_BITS(4), .CNT_BITS(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busA.slave)
   );

   forward_ctrl #(.REG_BITS(4), .CNT_BITS(2)) dutSat (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busB.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic setId(input int v, input int rs1, input int u1, input int rs2,
                        input int u2, input int rd, input int wr, input int ld,
                        input int fl);
      busA.valid_ID    = 1'(v);   busB.valid_ID    = 1'(v);
      busA.rs1_ID      = 4'(rs1); busB.rs1_ID      = 4'(rs1);
      busA.rs1_used_ID = 1'(u1);  busB.rs1_used_ID = 1'(u1);
      busA.rs2_ID      = 4'(rs2); busB.rs2_ID      = 4'(rs2);
      busA.rs2_used_ID = 1'(u2);  busB.rs2_used_ID = 1'(u2);
      busA.rd_ID       = 4'(rd);  busB.rd_ID       = 4'(rd);
      busA.wrReg_ID    = 1'(wr);  busB.wrReg_ID    = 1'(wr);
      busA.isLoad_ID   = 1'(ld);  busB.isLoad_ID   = 1'(ld);
      busA.flush       = 1'(fl);  busB.flush       = 1'(fl);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) step();
   endtask

   // Producer writing rd, no sources read.
   task automatic produce(input int rd, input int ld);
      setId(1, 0, 0, 0, 0, rd, 1, ld, 0);
      step();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      setId(1, 3, 1, 3, 1, 3, 1, 1, 0);
      #1;
      checkVal("rst_sel1",  int'(busA.reg_forward_sel1), 0);
      checkVal("rst_sel2",  int'(busA.reg_forward_sel2), 0);
      checkVal("rst_stall", int'(busA.stall), 0);
      checkVal("rst_count", int'(busA.stall_count), 0);
      step();
      step();
      reset_n = 1'b1;
      #1;

      // ALU chain: add r3, then sub reading r3
      produce(3, 0);
      setId(1, 3, 1, 0, 0, 8, 1, 0, 0);
      #1;
      checkVal("alu_sel1",  int'(busA.reg_forward_sel1), 1);
      checkVal("alu_stall", int'(busA.stall), 0);
      step();
      idle(3);

      // Distance: two intervening instructions -> WB
      produce(5, 0);
      produce(9, 0);
      produce(10, 0);
      setId(1, 0, 0, 5, 1, 11, 1, 0, 0);
      #1;
      checkVal("dist2_sel2", int'(busA.reg_forward_sel2), 3);
      checkVal("dist2_sel1", int'(busA.reg_forward_sel1), 0);
      step();
      idle(3);

      // Distance: one intervening instruction -> MEM
      produce(5, 0);
      produce(9, 0);
      setId(1, 0, 0, 5, 1, 11, 1, 0, 0);
      #1;
      checkVal("dist1_sel2", int'(busA.reg_forward_sel2), 2);
      step();
      idle(3);

      // Priority: r4 in MEM and WB -> MEM
      produce(4, 0);
      produce(4, 0);
      idle(1);
      setId(1, 4, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("prio_mem_sel1", int'(busA.reg_forward_sel1), 2);
      step();
      idle(3);

      // Priority: r4 in EX, MEM and WB -> EX
      produce(4, 0);
      produce(4, 0);
      produce(4, 0);
      setId(1, 4, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("prio_ex_sel1", int'(busA.reg_forward_sel1), 1);
      step();
      idle(3);

      // Independent operands from different stages, used/valid gating
      produce(6, 0);
      produce(11, 0);
      produce(12, 0);
      setId(1, 6, 1, 11, 1, 0, 0, 0, 0);
      #1;
      checkVal("indep_sel1", int'(busA.reg_forward_sel1), 3);
      checkVal("indep_sel2", int'(busA.reg_forward_sel2), 2);
      setId(1, 6, 1, 11, 0, 0, 0, 0, 0);
      #1;
      checkVal("unused_sel2", int'(busA.reg_forward_sel2), 0);
      setId(0, 6, 1, 11, 1, 0, 0, 0, 0);
      #1;
      checkVal("invalid_sel1", int'(busA.reg_forward_sel1), 0);
      step();
      idle(3);

      // A non-writing slot never matches
      setId(1, 0, 0, 0, 0, 13, 0, 0, 0);
      step();
      setId(1, 13, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("nowr_sel1", int'(busA.reg_forward_sel1), 0);
      step();
      idle(3);

      // Load-use: load r7, consumer rs1=r7
      produce(7, 1);
      setId(1, 7, 1, 0, 0, 14, 1, 0, 0);
      #1;
      checkVal("lu_stall",  int'(busA.stall), 1);
      checkVal("lu_sel1",   int'(busA.reg_forward_sel1), 1);
      checkVal("lu_count0", int'(busA.stall_count), 0);
      step();
      checkVal("lu_stall_next", int'(busA.stall), 0);
      checkVal("lu_sel1_next",  int'(busA.reg_forward_sel1), 2);
      checkVal("lu_count1",     int'(busA.stall_count), 1);
      step();
      idle(3);

      // Back-to-back dependent loads: one stall each
      produce(2, 1);
      setId(1, 2, 1, 0, 0, 3, 1, 1, 0);
      #1;
      checkVal("b2b_stall_a", int'(busA.stall), 1);
      step();
      checkVal("b2b_release_a", int'(busA.stall), 0);
      checkVal("b2b_sel1_a",    int'(busA.reg_forward_sel1), 2);
      checkVal("b2b_count_a",   int'(busA.stall_count), 2);
      step();
      setId(1, 0, 0, 3, 1, 15, 1, 0, 0);
      #1;
      checkVal("b2b_stall_b", int'(busA.stall), 1);
      step();
      checkVal("b2b_release_b", int'(busA.stall), 0);
      checkVal("b2b_sel2_b",    int'(busA.reg_forward_sel2), 2);
      checkVal("b2b_count_b",   int'(busA.stall_count), 3);
      checkVal("sat_reach",     int'(busB.stall_count), 3);
      step();
      idle(3);

      // Two more stalls: wide counter reaches 5, narrow one holds at 3
      for (int k = 0; k < 2; k++) begin
         produce(7, 1);
         setId(1, 0, 0, 7, 1, 0, 0, 0, 0);
         #1;
         checkVal("extra_stall", int'(busA.stall), 1);
         step();
         step();
         idle(3);
      end
      checkVal("count_five", int'(busA.stall_count), 5);
      checkVal("sat_hold",   int'(busB.stall_count), 3);

      // Register 0 never forwards
      produce(0, 0);
      setId(1, 0, 1, 0, 1, 0, 0, 0, 0);
      #1;
      checkVal("zero_sel1", int'(busA.reg_forward_sel1), 0);
      checkVal("zero_sel2", int'(busA.reg_forward_sel2), 0);
      step();
      idle(3);
      produce(0, 1);
      setId(1, 0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("zero_load_stall", int'(busA.stall), 0);
      step();
      idle(3);

      // Flush suppresses the load-use stall and squashes the decode slot
      produce(2, 1);
      setId(1, 2, 1, 0, 0, 15, 1, 0, 1);
      #1;
      checkVal("flush_stall", int'(busA.stall), 0);
      checkVal("flush_sel1",  int'(busA.reg_forward_sel1), 1);
      step();
      setId(1, 2, 1, 15, 1, 0, 0, 0, 0);
      #1;
      checkVal("flush_after_sel1", int'(busA.reg_forward_sel1), 2);
      checkVal("flush_bubble_sel2", int'(busA.reg_forward_sel2), 0);
      checkVal("flush_count",      int'(busA.stall_count), 5);
      step();
      idle(3);

      // Reset asserted in the middle of a stall
      produce(7, 1);
      setId(1, 7, 1, 7, 1, 14, 1, 0, 0);
      #1;
      checkVal("pre_rst_stall", int'(busA.stall), 1);
      reset_n = 1'b0;
      #1;
      checkVal("midrst_stall",  int'(busA.stall), 0);
      checkVal("midrst_sel1",   int'(busA.reg_forward_sel1), 0);
      checkVal("midrst_sel2",   int'(busA.reg_forward_sel2), 0);
      checkVal("midrst_count",  int'(busA.stall_count), 0);
      checkVal("midrst_countB", int'(busB.stall_count), 0);
      step();
      step();
      reset_n = 1'b1;
      #1;
      checkVal("postrst_sel1",  int'(busA.reg_forward_sel1), 0);
      checkVal("postrst_stall", int'(busA.stall), 0);
      step();
      setId(1, 14, 1, 0, 0, 0, 0, 0, 0);
      #1;
      checkVal("first_edge_sel1", int'(busA.reg_forward_sel1), 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter REG_BITS, default 4, SHALL set register-index width.
REQ-002 Parameter CNT_BITS, default 16, SHALL set stall-counter width.
REQ-003 Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-004 Ports:
- valid_ID  in  1  decode slot holds a real instruction.
- rs1_ID, rs2_ID  in  REG_BITS  decode source register indices.
- rs1_used_ID, rs2_used_ID  in  1  source actually read.
- rd_ID  in  REG_BITS  decode destination index.
- wrReg_ID  in  1  decode instruction writes rd_ID.
- isLoad_ID  in  1  decode instruction is a memory load.
- flush  in  1  taken branch/jump: squash decode slot.
REQ-005 Ports:
- reg_forward_sel1, reg_forward_sel2  out  2  operand source select, 0 none, 1 EX, 2 MEM, 3 WB.
- stall  out  1  hold PC and decode register, bubble into EX.
- stall_count  out  CNT_BITS  saturating count of stall cycles.

Function
REQ-006 Block SHALL hold three tracking slots EX, MEM, WB; each slot holds {v, wr, ld, rd}.
REQ-007 Slot "writes r" SHALL mean v=1, wr=1, rd=r, and r != 0.
REQ-008 reg_forward_selN SHALL be combinational from the current slots and ID inputs, valid in the same cycle.
REQ-009 If valid_ID=0 or rsN_used_ID=0, reg_forward_selN SHALL be 0.
REQ-010 Otherwise selN SHALL be 1 if EX writes rsN; else 2 if MEM writes rsN; else 3 if WB writes rsN; else 0. The youngest producer wins.
REQ-011 Index 0 SHALL never be forwarded; selN=0 whenever rsN_ID=0.
REQ-012 Load-use: stall SHALL be 1 when valid_ID=1, EX.ld=1, EX writes rsN, and rsN_used_ID=1, for either operand.
REQ-013 While stall=1, both forward selects SHALL still reflect REQ-010; the consumer ignores them.
REQ-014 flush=1 SHALL force stall=0 in the same cycle.
REQ-015 Each rising clk edge SHALL shift WB<=MEM and MEM<=EX.
REQ-016 On the same edge, EX SHALL load a bubble (v=0, others 0) if stall=1, flush=1, or valid_ID=0.
REQ-017 Otherwise EX SHALL load {1, wrReg_ID, isLoad_ID, rd_ID}.
REQ-018 A load stall SHALL last exactly one cycle: the next cycle has the load in MEM and the dependent operand selects 2.
REQ-019 Back-to-back loads with dependence SHALL each produce exactly one stall cycle.
REQ-020 stall_count SHALL increment by 1 on each edge where stall=1.
REQ-021 stall_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 wr=0 slots and v=0 slots SHALL never match, regardless of rd.
REQ-023 Both operands MAY match different stages in the same cycle; each select SHALL be resolved independently.

Reset
REQ-024 reset_n=0 SHALL asynchronously clear all slots to bubble and stall_count to 0.
REQ-025 While reset_n=0, reg_forward_sel1, reg_forward_sel2, and stall SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL drop stall immediately; no stale forward SHALL appear after reset deasserts.
REQ-027 First edge after reset_n rises SHALL behave per REQ-015 to REQ-017 with all prior slots empty.

Verification
REQ-028 ALU chain: ID add r3 then ID sub rs1=r3, non-load -> next cycle sel1=1, stall=0.
REQ-029 Distance: producer r5 followed by two independent instructions, then consumer rs2=r5 -> sel2=3; with one intervening instruction -> sel2=2.
REQ-030 Priority: r4 written in MEM and WB, consumer rs1=r4 -> sel1=2. Add a write of r4 in EX -> sel1=1.
REQ-031 Load-use: load r7 then rs1=r7 -> stall=1 for one cycle, stall_count 0->1; following cycle sel1=2, stall=0.
REQ-032 Zero and flush cases:
- producer rd=0, consumer rs1=0 -> sel1=0.
- load r2 in EX, consumer rs1=r2 with flush=1 -> stall=0, EX becomes bubble.
REQ-033 Saturation and reset:
- CNT_BITS=2, five stall cycles -> stall_count holds 3.
- reset_n pulsed low mid-stall -> stall, selects, and count all 0 immediately.
